// File: rtl/motion_pkg.sv
// Shared definitions for the step/dir receiver: FSM encoding, synchronizer depth
// and a saturating counter helper.
package motion_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_POST = 2'd2
  } step_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high clear.
module sync_2ff
  import motion_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= '0;
    end else begin
      // NOTE: non-blocking keeps each flop sampling the previous stage's old value.
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/motor_step_rx.sv
// Step/dir receiver: synchronizes the external lines, counts position and flags
// setup, pulse-width and hold timing violations as sticky errors.
module motor_step_rx
  import motion_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step_in,
  input  logic        dir_in,
  input  logic [31:0] pre_n,
  input  logic [31:0] pulse_n,
  input  logic [31:0] post_n,
  input  logic        pos_load,
  input  logic [31:0] pos_value,
  input  logic        err_clr,
  output logic        step_stb,
  output logic        step_dir,
  output logic [31:0] position,
  output logic        err_setup,
  output logic        err_pulse,
  output logic        err_hold
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

  logic s_step;
  logic s_dir;

  sync_2ff u_sync_step (.clk(clk), .reset(reset), .d(step_in), .q(s_step));
  sync_2ff u_sync_dir  (.clk(clk), .reset(reset), .d(dir_in),  .q(s_dir));

  logic                step_p;
  logic                dir_p;
  logic                step_prev;
  logic                dir_prev;
  logic                armed;
  logic [SETTLE_W-1:0] settle;
  step_state_t         state;
  logic [31:0]         dir_cnt;
  logic [31:0]         width_cnt;
  logic [31:0]         hold_cnt;

  logic        step_lvl;
  logic        rise;
  logic        fall;
  logic        dir_chg;
  logic [31:0] dir_cnt_eff;
  logic        set_setup;
  logic        set_pulse;
  logic        set_hold;

  // Edges are only honoured once a low step level has been seen after reset,
  // so a line already high at reset release is never taken as a new step.
  assign step_lvl    = step_p & armed;
  assign rise        = step_lvl & ~step_prev;
  assign fall        = ~step_lvl & step_prev;
  assign dir_chg     = dir_p ^ dir_prev;
  assign dir_cnt_eff = dir_chg ? 32'd0 : dir_cnt;

  always_comb begin
    set_setup = rise && (dir_cnt_eff < pre_n);
    set_pulse = (state == ST_HIGH) && fall && (width_cnt < pulse_n);
    set_hold  = 1'b0;
    if (state == ST_HIGH && dir_chg) begin
      set_hold = 1'b1;
    end
    if (state == ST_POST && hold_cnt < post_n && (dir_chg || rise)) begin
      set_hold = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_p    <= 1'b0;
      dir_p     <= 1'b0;
      step_prev <= 1'b0;
      dir_prev  <= 1'b0;
      armed     <= 1'b0;
      settle    <= '0;
      state     <= ST_IDLE;
      dir_cnt   <= '0;
      width_cnt <= '0;
      hold_cnt  <= '0;
      step_stb  <= 1'b0;
      step_dir  <= 1'b0;
      position  <= '0;
      err_setup <= 1'b0;
      err_pulse <= 1'b0;
      err_hold  <= 1'b0;
    end else begin
      step_p    <= s_step;
      dir_p     <= s_dir;
      step_prev <= step_lvl;
      dir_prev  <= dir_p;

      if (settle != SETTLE_W'(SYNC_STAGES)) begin
        settle <= settle + 1'b1;
      end else if (!s_step) begin
        armed <= 1'b1;
      end

      dir_cnt  <= dir_chg ? 32'd0 : sat_inc(dir_cnt);
      step_stb <= rise;
      if (rise) begin
        step_dir <= dir_p;
      end

      case (state)
        ST_IDLE: begin
          if (rise) begin
            state     <= ST_HIGH;
            width_cnt <= 32'd1;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state    <= ST_POST;
            hold_cnt <= '0;
          end else begin
            width_cnt <= sat_inc(width_cnt);
          end
        end
        ST_POST: begin
          if (rise) begin
            state     <= ST_HIGH;
            width_cnt <= 32'd1;
          end else if (hold_cnt >= post_n) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= sat_inc(hold_cnt);
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (pos_load) begin
        position <= pos_value;
      end else if (step_stb) begin
        position <= step_dir ? position + 32'd1 : position - 32'd1;
      end

      err_setup <= set_setup | (err_setup & ~err_clr);
      err_pulse <= set_pulse | (err_pulse & ~err_clr);
      err_hold  <= set_hold  | (err_hold  & ~err_clr);
    end
  end

endmodule

// File: tb/tb_motor_step_rx.sv
// Scenario bench for motor_step_rx; a scoreboard queue holds the expected
// direction of every step strobe, drained by a monitor on the falling edge.
module tb_motor_step_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_in;
  logic        dir_in;
  logic [31:0] pre_n;
  logic [31:0] pulse_n;
  logic [31:0] post_n;
  logic        pos_load;
  logic [31:0] pos_value;
  logic        err_clr;
  logic        step_stb;
  logic        step_dir;
  logic [31:0] position;
  logic        err_setup;
  logic        err_pulse;
  logic        err_hold;

  int checks   = 0;
  int failures = 0;
  int stb_seen = 0;
  logic exp_q[$];

  motor_step_rx dut (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .pre_n(pre_n), .pulse_n(pulse_n), .post_n(post_n),
    .pos_load(pos_load), .pos_value(pos_value), .err_clr(err_clr),
    .step_stb(step_stb), .step_dir(step_dir), .position(position),
    .err_setup(err_setup), .err_pulse(err_pulse), .err_hold(err_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && step_stb === 1'b1) begin
      stb_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_step_stb at %0t: no strobe expected", $time);
      end else begin
        logic exp_dir;
        exp_dir = exp_q.pop_front();
        if (step_dir !== exp_dir) begin
          failures++;
          $display("FAIL step_dir at %0t: got %b expected %b", $time, step_dir, exp_dir);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic expect_errs(input string name, input logic s, input logic p, input logic h);
    checks++;
    if ({err_setup, err_pulse, err_hold} !== {s, p, h}) begin
      failures++;
      $display("FAIL %s errs(setup,pulse,hold): got %b%b%b expected %b%b%b",
               name, err_setup, err_pulse, err_hold, s, p, h);
    end
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b1; step_in = 1'b0; dir_in = 1'b0;
    pre_n = 32'd5; pulse_n = 32'd15; post_n = 32'd20;
    pos_load = 1'b0; pos_value = '0; err_clr = 1'b0;
    tick(3);
    expect_val("reset_position", position, 32'd0);
    expect_val("reset_stb_dir", {30'd0, step_stb, step_dir}, 32'd0);
    expect_errs("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(5);
  endtask

  task automatic test_basic();
    int seen0;
    dir_in = 1'b1;
    tick(10);
    seen0 = stb_seen;
    exp_q.push_back(1'b1);
    step_in = 1'b1;
    tick(3);
    expect_val("latency_early", {31'd0, step_stb}, 32'd0);
    tick(1);
    expect_val("latency_exact", {31'd0, step_stb}, 32'd1);
    tick(11);
    step_in = 1'b0;
    tick(30);
    expect_val("basic_stb_count", stb_seen - seen0, 32'd1);
    expect_val("basic_position", position, 32'd1);
    expect_errs("basic", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_setup();
    dir_in = 1'b0;
    tick(30);
    dir_in = 1'b1;
    tick(2);
    exp_q.push_back(1'b1);
    step_in = 1'b1;
    tick(15);
    step_in = 1'b0;
    tick(30);
    expect_errs("setup", 1'b1, 1'b0, 1'b0);
    expect_val("setup_position", position, 32'd2);
    clear_errs();
    expect_errs("setup_cleared", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_pulse();
    int seen0;
    seen0 = stb_seen;
    exp_q.push_back(1'b1);
    step_in = 1'b1;
    tick(8);
    step_in = 1'b0;
    tick(30);
    expect_val("pulse_stb_count", stb_seen - seen0, 32'd1);
    expect_errs("pulse", 1'b0, 1'b1, 1'b0);
    expect_val("pulse_position", position, 32'd3);
    clear_errs();
  endtask

  task automatic test_hold();
    exp_q.push_back(1'b1);
    step_in = 1'b1;
    tick(15);
    step_in = 1'b0;
    tick(10);
    // Dir flips and the next step rises together, still inside the hold window.
    dir_in = 1'b0;
    exp_q.push_back(1'b0);
    step_in = 1'b1;
    tick(15);
    step_in = 1'b0;
    tick(30);
    expect_errs("hold", 1'b1, 1'b0, 1'b1);
    expect_val("hold_position", position, 32'd3);
    clear_errs();
  endtask

  task automatic test_wrap_load();
    dir_in = 1'b1;
    pos_load = 1'b1; pos_value = 32'hFFFF_FFFF;
    tick(1);
    pos_load = 1'b0;
    tick(10);
    expect_val("load_value", position, 32'hFFFF_FFFF);
    exp_q.push_back(1'b1);
    step_in = 1'b1;
    tick(15);
    step_in = 1'b0;
    tick(30);
    expect_val("wrap_position", position, 32'd0);
    exp_q.push_back(1'b1);
    step_in = 1'b1;
    tick(4);
    pos_load = 1'b1; pos_value = 32'h10;
    tick(1);
    pos_load = 1'b0;
    tick(10);
    step_in = 1'b0;
    tick(30);
    expect_val("load_wins", position, 32'h10);
    expect_errs("wrap_load", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_pulse();
    int seen0;
    exp_q.push_back(1'b1);
    step_in = 1'b1;
    tick(6);
    reset = 1'b1;
    tick(2);
    expect_val("midreset_position", position, 32'd0);
    reset = 1'b0;
    seen0 = stb_seen;
    tick(20);
    expect_val("midreset_no_stb", stb_seen - seen0, 32'd0);
    step_in = 1'b0;
    tick(5);
    exp_q.push_back(1'b1);
    step_in = 1'b1;
    tick(3);
    expect_val("rearm_latency_early", {31'd0, step_stb}, 32'd0);
    tick(1);
    expect_val("rearm_latency_exact", {31'd0, step_stb}, 32'd1);
    tick(11);
    step_in = 1'b0;
    tick(30);
    expect_val("rearm_position", position, 32'd1);
    expect_errs("rearm", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_setup();
    test_pulse();
    test_hold();
    test_wrap_load();
    test_reset_mid_pulse();
    expect_val("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
